run_sequencer: RTL and testbench

Start/stop sequencer for the single-cycle core. It accepts a host req handshake and selects one of four program entry points. It loads that entry point into the program counter, enables the core until the decoder flags a halt instruction or a cycle watchdog expires, then drains the registered flags and holds done until the host drops req. It sits between the top-level req/done pins and the PC / flag-register enables.

---
 rtl/run_sequencer.sv | 146 ++++++++++++++
 tb/tb_run_sequencer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - start/stop sequencer: entry-point load, run with halt/abort/watchdog exit, drain, done handshake
module run_sequencer #(
  parameter int D         = 12,
  parameter int CW        = 16,
  parameter int START0    = 0,
  parameter int START1    = 256,
  parameter int START2    = 512,
  parameter int START3    = 768,
  parameter int TIMEOUT   = 65535,
  parameter int DRAIN_CYC = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic [1:0]    prog_sel,
  input  logic          halt,
  input  logic          abort,
  output logic          core_en,
  output logic          pc_load,
  output logic [D-1:0]  pc_start,
  output logic          busy,
  output logic          done,
  output logic          timed_out,
  output logic          aborted,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [D-1:0]  ENTRY0 = D'(START0);
  localparam logic [D-1:0]  ENTRY1 = D'(START1);
  localparam logic [D-1:0]  ENTRY2 = D'(START2);
  localparam logic [D-1:0]  ENTRY3 = D'(START3);
  localparam logic [CW-1:0] WDOG   = CW'(TIMEOUT);
  localparam logic [3:0]    DRAIN  = 4'(DRAIN_CYC);

  state_t        state;
  logic [3:0]    drain_cnt;
  logic [D-1:0]  start_sel;
  logic [CW-1:0] cnt_inc;
  logic          wdog_hit;

  always_comb begin
    start_sel = ENTRY0;
    case (prog_sel)
      2'd0: start_sel = ENTRY0;
      2'd1: start_sel = ENTRY1;
      2'd2: start_sel = ENTRY2;
      2'd3: start_sel = ENTRY3;
      default: start_sel = ENTRY0;
    endcase
  end

  // TIMEOUT < 2^CW, so the increment never wraps before the watchdog fires
  assign cnt_inc  = cycle_cnt + CW'(1);
  assign wdog_hit = (cnt_inc == WDOG);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      drain_cnt <= 4'd0;
      core_en   <= 1'b0;
      pc_load   <= 1'b0;
      pc_start  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timed_out <= 1'b0;
      aborted   <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // pc_start doubles as the latched program selection
          if (req) begin
            state     <= S_LOAD;
            pc_load   <= 1'b1;
            busy      <= 1'b1;
            pc_start  <= start_sel;
            cycle_cnt <= '0;
          end
        end

        S_LOAD: begin
          pc_load   <= 1'b0;
          timed_out <= 1'b0;
          aborted   <= 1'b0;
          if (abort) begin
            state     <= S_DRAIN;
            aborted   <= 1'b1;
            drain_cnt <= DRAIN;
          end else begin
            state   <= S_RUN;
            core_en <= 1'b1;
          end
        end

        S_RUN: begin
          cycle_cnt <= cnt_inc;
          if (abort || halt || wdog_hit) begin
            state     <= S_DRAIN;
            core_en   <= 1'b0;
            drain_cnt <= DRAIN;
          end
          // abort outranks halt, halt outranks the watchdog
          if (abort) begin
            aborted <= 1'b1;
          end else if (!halt && wdog_hit) begin
            timed_out <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (drain_cnt <= 4'd1) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end

        S_DONE: begin
          if (!req) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: begin
          state   <= S_IDLE;
          core_en <= 1'b0;
          pc_load <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized self-checking bench for run_sequencer
module tb_run_sequencer;
  localparam int D = 12;
  localparam int CW = 16;
  localparam int TMO = 10;
  localparam int DRN = 2;
  localparam int LOAD_AB = 99;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic halt = 1'b0;
  logic abort = 1'b0;
  logic core_en, pc_load, busy, done, timed_out, aborted;
  logic [D-1:0] pc_start;
  logic [CW-1:0] cycle_cnt;

  int total = 0;
  int bad = 0;
  int entries[4] = '{0, 256, 512, 768};

  always #5 clk = ~clk;

  run_sequencer #(.D(D), .CW(CW), .START0(0), .START1(256), .START2(512), .START3(768),
                  .TIMEOUT(TMO), .DRAIN_CYC(DRN)) dut (
    .clk(clk), .reset(reset), .req(req), .prog_sel(prog_sel), .halt(halt), .abort(abort),
    .core_en(core_en), .pc_load(pc_load), .pc_start(pc_start), .busy(busy), .done(done),
    .timed_out(timed_out), .aborted(aborted), .cycle_cnt(cycle_cnt)
  );

  // Reference: first RUN cycle where abort, halt or the watchdog bound applies ends the run.
  task automatic ref_run(input int h, input int a, output int cnt, output bit to, output bit ab);
    cnt = 0; to = 1'b0; ab = 1'b0;
    if (a == LOAD_AB) begin
      ab = 1'b1;
      return;
    end
    for (int c = 1; c <= TMO; c++) begin
      if (a == c) begin cnt = c; ab = 1'b1; return; end
      if (h == c) begin cnt = c; return; end
      if (c == TMO) begin cnt = c; to = 1'b1; return; end
    end
  endtask

  task automatic do_run(input string nm, input int sel, input int h, input int a, input bit tog, input int hold);
    int cnt; bit to; bit ab;
    int idx, n_load, n_en, first_en, done_idx, seen_start, cnt_at_load, errs;
    ref_run(h, a, cnt, to, ab);
    idx = 0; n_load = 0; n_en = 0; first_en = -1; done_idx = -1; seen_start = -1; cnt_at_load = -1;
    req = 1'b1; prog_sel = 2'(sel); halt = 1'b0; abort = 1'b0;
    while (done_idx < 0 && idx < 80) begin
      @(posedge clk); #1; idx++;
      halt = 1'b0; abort = 1'b0;
      if (pc_load) begin
        n_load++; seen_start = int'(pc_start); cnt_at_load = int'(cycle_cnt);
        if (a == LOAD_AB) abort = 1'b1;
      end
      if (core_en) begin
        n_en++;
        if (first_en < 0) first_en = idx;
        if (h == n_en) halt = 1'b1;
        if (a == n_en) abort = 1'b1;
        if (tog) begin req = 1'($urandom_range(0, 1)); prog_sel = 2'($urandom); end
      end else begin
        req = 1'b1;
      end
      if (done) done_idx = idx;
    end
    halt = 1'b0; abort = 1'b0;
    total++;
    if (done_idx < 0) begin
      bad++; $display("FAIL %s done_wait: done never rose within 80 cycles, required by cycle %0d", nm, 2 + cnt + DRN);
      return;
    end
    total++; if (n_load !== 1) begin bad++; $display("FAIL %s pc_load_count: got %0d want 1", nm, n_load); end
    total++; if (seen_start !== entries[sel]) begin bad++; $display("FAIL %s pc_start: got %0d want %0d", nm, seen_start, entries[sel]); end
    total++; if (cnt_at_load !== 0) begin bad++; $display("FAIL %s cnt_at_load: got %0d want 0", nm, cnt_at_load); end
    total++; if (first_en !== ((a == LOAD_AB) ? -1 : 2)) begin bad++; $display("FAIL %s first_core_en: got %0d want %0d", nm, first_en, (a == LOAD_AB) ? -1 : 2); end
    total++; if (n_en !== cnt) begin bad++; $display("FAIL %s core_en_cycles: got %0d want %0d", nm, n_en, cnt); end
    total++; if (done_idx !== 2 + cnt + DRN) begin bad++; $display("FAIL %s done_latency: got %0d want %0d", nm, done_idx, 2 + cnt + DRN); end
    total++; if (cycle_cnt !== CW'(cnt)) begin bad++; $display("FAIL %s cycle_cnt: got %0d want %0d", nm, cycle_cnt, cnt); end
    total++; if (timed_out !== to) begin bad++; $display("FAIL %s timed_out: got %0b want %0b", nm, timed_out, to); end
    total++; if (aborted !== ab) begin bad++; $display("FAIL %s aborted: got %0b want %0b", nm, aborted, ab); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done: got %0b want 0", nm, busy); end
    if (hold > 0) begin
      errs = 0;
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        if (!done || pc_load || busy || core_en) errs++;
      end
      total++; if (errs !== 0) begin bad++; $display("FAIL %s hold_done: %0d bad cycles, want 0", nm, errs); end
      total++; if (cycle_cnt !== CW'(cnt)) begin bad++; $display("FAIL %s hold_cycle_cnt: got %0d want %0d", nm, cycle_cnt, cnt); end
    end
    req = 1'b0;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s release: done=%0b busy=%0b want 0 0", nm, done, busy); end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({core_en, pc_load, pc_start, busy, done, timed_out, aborted, cycle_cnt} !== '0) begin
      bad++; $display("FAIL reset_outputs: en=%0b ld=%0b st=%0d busy=%0b done=%0b to=%0b ab=%0b cnt=%0d want all 0",
                      core_en, pc_load, pc_start, busy, done, timed_out, aborted, cycle_cnt);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || pc_load !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%0b pc_load=%0b want 0 0", busy, pc_load); end
  endtask

  task automatic test_async_reset();
    int n_en, guard;
    req = 1'b1; prog_sel = 2'd1; n_en = 0; guard = 0;
    while (n_en < 4 && guard < 40) begin
      @(posedge clk); #1; guard++;
      if (core_en) n_en++;
    end
    #3 reset = 1'b0;
    #1;
    total++;
    if (core_en !== 1'b0 || busy !== 1'b0 || cycle_cnt !== '0) begin
      bad++; $display("FAIL async_reset: en=%0b busy=%0b cnt=%0d want 0 0 0 (run cycles seen %0d)", core_en, busy, cycle_cnt, n_en);
    end
    prog_sel = 2'd2;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    total++; if (pc_load !== 1'b1 || pc_start !== D'(512)) begin bad++; $display("FAIL reload_after_reset: pc_load=%0b pc_start=%0d want 1 512", pc_load, pc_start); end
    total++; if (cycle_cnt !== '0) begin bad++; $display("FAIL reload_cnt: got %0d want 0", cycle_cnt); end
    guard = 0;
    while (!done && guard < 40) begin @(posedge clk); #1; guard++; end
    total++; if (done !== 1'b1 || cycle_cnt !== CW'(TMO) || timed_out !== 1'b1) begin
      bad++; $display("FAIL reload_run: done=%0b cnt=%0d to=%0b want 1 %0d 1", done, cycle_cnt, timed_out, TMO);
    end
    req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int h, a;
    for (int r = 0; r < 12; r++) begin
      h = $urandom_range(0, 12);
      a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
      if ($urandom_range(0, 7) == 0) a = LOAD_AB;
      do_run("random", $urandom_range(0, 3), h, a, 1'($urandom_range(0, 1)), 0);
    end
  endtask

  initial begin
    test_reset();
    do_run("halt5", 1, 5, 0, 1'b0, 0);
    do_run("watchdog", 0, 0, 0, 1'b0, 0);
    do_run("halt_and_wdog", 2, 10, 0, 1'b0, 0);
    do_run("abort_with_halt", 3, 3, 3, 1'b0, 0);
    do_run("abort_in_load", 0, 0, LOAD_AB, 1'b0, 0);
    do_run("hold_done", 0, 2, 0, 1'b0, 20);
    do_run("back_to_back", 3, 4, 0, 1'b0, 0);
    do_run("toggle_in_run", 1, 6, 0, 1'b1, 0);
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time bound");
    $fatal(1);
  end
endmodule
